// File: rtl/led_pwm_driver.sv
// Four-channel LED PWM driver. A prescaler and a 4-bit phase counter set the period.
// Duty writes are held in one pending slot and only reach the active registers at a period wrap.
module led_pwm_driver #(
  parameter int PRESCALE = 4,
  parameter int NCH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       duty_valid,
  output logic       duty_ready,
  input  logic [1:0] duty_ch,
  input  logic [3:0] duty_data,
  output logic [3:0] led,
  output logic       period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    phase_q, phase_d;
  logic [3:0]    duty_q [NCH];
  logic [3:0]    duty_d [NCH];
  logic          pending_q, pending_d;
  logic [1:0]    pend_ch_q, pend_ch_d;
  logic [3:0]    pend_data_q, pend_data_d;
  logic [3:0]    led_q, led_d;
  logic          ps_q, ps_d;
  logic          tick, wrap, accept;

  always_comb begin
    tick        = (pre_q == PRE_MAX);
    wrap        = tick && (phase_q == 4'd15);
    accept      = duty_valid && !pending_q;
    pre_d       = tick ? '0 : pre_q + 1'b1;
    phase_d     = phase_q + {3'b000, tick};
    duty_d      = duty_q;
    pending_d   = pending_q;
    pend_ch_d   = pend_ch_q;
    pend_data_d = pend_data_q;
    // Commit and accept are exclusive: accept needs an empty slot, commit needs a full one.
    if (wrap && pending_q) begin
      duty_d[pend_ch_q] = pend_data_q;
      pending_d         = 1'b0;
    end
    if (accept) begin
      pending_d   = 1'b1;
      pend_ch_d   = duty_ch;
      pend_data_d = duty_data;
    end
    for (int i = 0; i < NCH; i++) begin
      led_d[i] = (phase_q < duty_q[i]);
    end
    ps_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q       <= '0;
      phase_q     <= 4'd0;
      for (int i = 0; i < NCH; i++) begin
        duty_q[i] <= 4'd0;
      end
      pending_q   <= 1'b0;
      pend_ch_q   <= 2'd0;
      pend_data_q <= 4'd0;
      led_q       <= 4'd0;
      ps_q        <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      phase_q     <= phase_d;
      duty_q      <= duty_d;
      pending_q   <= pending_d;
      pend_ch_q   <= pend_ch_d;
      pend_data_q <= pend_data_d;
      led_q       <= led_d;
      ps_q        <= ps_d;
    end
  end

  assign duty_ready   = !pending_q;
  assign led          = led_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver: a PRESCALE=4 instance for the main scenarios
// and a PRESCALE=1 instance for the short-period build.
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       dutyValid, dutyValid1;
  logic [1:0] dutyCh, dutyCh1;
  logic [3:0] dutyData, dutyData1;
  logic       dutyReady, dutyReady1;
  logic [3:0] led, led1;
  logic       periodStart, periodStart1;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [3:0] ledHist [0:127];
  logic       psHist  [0:127];

  led_pwm_driver #(.PRESCALE(4), .NCH(4)) dut (
    .clk(clk), .rst(rst), .duty_valid(dutyValid), .duty_ready(dutyReady),
    .duty_ch(dutyCh), .duty_data(dutyData), .led(led), .period_start(periodStart)
  );

  led_pwm_driver #(.PRESCALE(1), .NCH(4)) dut1 (
    .clk(clk), .rst(rst), .duty_valid(dutyValid1), .duty_ready(dutyReady1),
    .duty_ch(dutyCh1), .duty_data(dutyData1), .led(led1), .period_start(periodStart1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Called at a negedge; holds the request until accepted, returns refused edges.
  task automatic applyStimulus(input bit sel, input logic [1:0] ch, input logic [3:0] data,
                               output int waits);
    logic rdy;
    waits = 0;
    if (sel) begin dutyValid1 = 1'b1; dutyCh1 = ch; dutyData1 = data; end
    else     begin dutyValid  = 1'b1; dutyCh  = ch; dutyData  = data; end
    while (1) begin
      rdy = sel ? dutyReady1 : dutyReady;
      @(posedge clk);
      if (rdy) break;
      waits++;
      if (waits >= 300) break;
      @(negedge clk);
    end
    @(negedge clk);
    if (sel) dutyValid1 = 1'b0;
    else     dutyValid  = 1'b0;
  endtask

  task automatic waitPeriodStart(input bit sel, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!(sel ? periodStart1 : periodStart) && n < 300);
  endtask

  task automatic measure(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ledHist[i] = sel ? led1 : led;
      psHist[i]  = sel ? periodStart1 : periodStart;
    end
  endtask

  function automatic int countHigh(input int ch, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(ledHist[i][ch]);
    return c;
  endfunction

  function automatic int countPs(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(psHist[i]);
    return c;
  endfunction

  initial begin
    int w, n;
    rst = 1'b1;
    dutyValid = 1'b0; dutyCh = 2'd0; dutyData = 4'd0;
    dutyValid1 = 1'b0; dutyCh1 = 2'd0; dutyData1 = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_led", int'(led), 0);
    checkOutput("reset_ready", int'(dutyReady), 1);
    checkOutput("reset_ps", int'(periodStart), 0);
    rst = 1'b0;

    $display("[TB] first period after reset");
    waitPeriodStart(1'b0, n);
    checkOutput("first_ps_edges", n, 64);

    $display("[TB] half duty on ch0");
    applyStimulus(1'b0, 2'd0, 4'd8, w);
    checkOutput("half_wait", w, 0);
    waitPeriodStart(1'b0, n);
    checkOutput("half_commit_edges", n, 63);
    measure(1'b0, 64);
    checkOutput("half_ch0_high", countHigh(0, 0, 31), 32);
    checkOutput("half_ch0_low", countHigh(0, 32, 63), 0);
    checkOutput("half_others", countHigh(1, 0, 63) + countHigh(2, 0, 63) + countHigh(3, 0, 63), 0);
    checkOutput("half_ps_mid", countPs(0, 62), 0);
    checkOutput("half_ps_end", int'(psHist[63]), 1);

    $display("[TB] extremes ch1=0 ch2=15");
    applyStimulus(1'b0, 2'd1, 4'd0, w);
    checkOutput("ext_wait_a", w, 0);
    applyStimulus(1'b0, 2'd2, 4'd15, w);
    checkOutput("ext_wait_b", w, 63);
    waitPeriodStart(1'b0, n);
    checkOutput("ext_commit_edges", n, 63);
    measure(1'b0, 64);
    checkOutput("ext_ch2_high", countHigh(2, 0, 59), 60);
    checkOutput("ext_ch2_tail", countHigh(2, 60, 63), 0);
    checkOutput("ext_ch1", countHigh(1, 0, 63), 0);
    checkOutput("ext_ch0", countHigh(0, 0, 63), 32);

    $display("[TB] back-pressure ch0=3 then ch1=5");
    applyStimulus(1'b0, 2'd0, 4'd3, w);
    checkOutput("bp_wait_a", w, 0);
    checkOutput("bp_ready_low", int'(dutyReady), 0);
    applyStimulus(1'b0, 2'd1, 4'd5, w);
    checkOutput("bp_wait_b", w, 63);
    measure(1'b0, 63);
    checkOutput("bp_p1_ch0", countHigh(0, 0, 62), 11);
    checkOutput("bp_p1_ch1", countHigh(1, 0, 62), 0);
    checkOutput("bp_p1_ps", int'(psHist[62]), 1);
    measure(1'b0, 64);
    checkOutput("bp_p2_ch0_head", countHigh(0, 0, 11), 12);
    checkOutput("bp_p2_ch0_tail", countHigh(0, 12, 63), 0);
    checkOutput("bp_p2_ch1", countHigh(1, 0, 19), 20);
    checkOutput("bp_p2_ch2", countHigh(2, 0, 63), 60);

    $display("[TB] write landing on the wrap cycle");
    repeat (63) @(negedge clk);
    applyStimulus(1'b0, 2'd3, 4'd4, w);
    checkOutput("wrapw_wait", w, 0);
    checkOutput("wrapw_ps", int'(periodStart), 1);
    checkOutput("wrapw_ready", int'(dutyReady), 0);
    measure(1'b0, 64);
    checkOutput("wrapw_p1_ch3", countHigh(3, 0, 63), 0);
    checkOutput("wrapw_p1_ps", int'(psHist[63]), 1);
    measure(1'b0, 64);
    checkOutput("wrapw_p2_head", countHigh(3, 0, 15), 16);
    checkOutput("wrapw_p2_tail", countHigh(3, 16, 63), 0);

    $display("[TB] async reset with a pending write");
    applyStimulus(1'b0, 2'd0, 4'd15, w);
    checkOutput("rst_wait", w, 0);
    repeat (10) @(negedge clk);
    checkOutput("rst_pre_pending", int'(dutyReady), 0);
    checkOutput("rst_pre_led", int'(led), 15);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_led", int'(led), 0);
    checkOutput("rst_async_ready", int'(dutyReady), 1);
    checkOutput("rst_async_ps", int'(periodStart), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waitPeriodStart(1'b0, n);
    checkOutput("rst_ps_edges", n, 64);
    measure(1'b0, 64);
    checkOutput("rst_no_commit", countHigh(0, 0, 63) + countHigh(1, 0, 63) +
                countHigh(2, 0, 63) + countHigh(3, 0, 63), 0);
    checkOutput("rst_ps_end", int'(psHist[63]), 1);

    $display("[TB] PRESCALE=1 instance");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitPeriodStart(1'b1, n);
    checkOutput("p1_first_ps", n, 16);
    applyStimulus(1'b1, 2'd0, 4'd1, w);
    checkOutput("p1_wait", w, 0);
    waitPeriodStart(1'b1, n);
    checkOutput("p1_commit_edges", n, 15);
    measure(1'b1, 32);
    checkOutput("p1_led_s0", countHigh(0, 0, 0), 1);
    checkOutput("p1_led_low_a", countHigh(0, 1, 15), 0);
    checkOutput("p1_led_s16", countHigh(0, 16, 16), 1);
    checkOutput("p1_led_low_b", countHigh(0, 17, 31), 0);
    checkOutput("p1_ps_15", int'(psHist[15]), 1);
    checkOutput("p1_ps_31", int'(psHist[31]), 1);
    checkOutput("p1_ps_count", countPs(0, 31), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning clk cycles per PWM tick; legal range 1..256.
REQ-002 SHALL have parameter NCH, default 4, meaning number of LED channels; fixed at 4 for this revision.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port duty_valid, input, 1 bit: duty write request.
REQ-006 SHALL have port duty_ready, output, 1 bit: block can accept a duty write.
REQ-007 SHALL have port duty_ch, input, 2 bits: target channel index.
REQ-008 SHALL have port duty_data, input, 4 bits: duty value 0..15.
REQ-009 SHALL have port led, output, 4 bits: registered PWM outputs; led[i] belongs to channel i.
REQ-010 SHALL have port period_start, output, 1 bit: one-clk pulse at each PWM period boundary.

Function
REQ-011 SHALL contain a prescaler counter, 0..PRESCALE-1; tick asserted in the clk where prescaler == PRESCALE-1, after which the prescaler returns to 0.
REQ-012 SHALL contain a 4-bit phase counter incrementing by 1 on each tick, wrapping 15 -> 0; PWM period = 16*PRESCALE clk.
REQ-013 SHALL define wrap as tick && phase == 15.
REQ-014 SHALL hold four 4-bit active duty registers, duty[0..3].
REQ-015 SHALL register led[i] <= (phase < duty[i]) every clk; led is one clk behind the phase/duty state.
REQ-016 Duty 0 SHALL give led[i] constantly 0; duty 15 SHALL give 15 of 16 ticks high; full-on is not supported.
REQ-017 SHALL accept a write when duty_valid && duty_ready are both high on a rising edge, capturing duty_ch and duty_data into a single pending slot and setting pending.
REQ-018 SHALL drive duty_ready = !pending, combinationally from the register.
REQ-019 On a wrap cycle with pending set, SHALL copy the pending value into duty[pending_ch] and clear pending.
REQ-020 Within one period, SHALL never change active duty registers except at a wrap; no mid-period glitching.
REQ-021 A write accepted in the wrap cycle itself (pending was clear) SHALL NOT commit at that wrap; it SHALL commit at the next wrap.
REQ-022 While pending is set, SHALL ignore duty_valid; the source holds duty_ch/duty_data stable until duty_ready is high.
REQ-023 SHALL register period_start, high for exactly the one clk following each wrap.
REQ-024 With PRESCALE=1, SHALL assert tick every clk, giving a period of 16 clk.

Reset
REQ-025 While rst is high, SHALL hold prescaler=0, phase=0, duty[0..3]=0, pending=0, led=4'b0000, period_start=0; duty_ready reads 1.
REQ-026 Reset asserted mid-period or with a write pending SHALL discard the pending write.
REQ-027 After rst deasserts, SHALL start counting from phase 0 on the first clk edge.

Verification
REQ-028 Reset check: pulse rst mid-period while pending=1 -> led=0000, duty_ready=1 immediately (async); no commit at the next wrap.
REQ-029 Half duty (PRESCALE=4): write ch0=8 -> after next wrap, led[0] is high 32 clk and low 32 clk per 64-clk period; led[3:1]=000.
REQ-030 Extremes: ch1=0 and ch2=15 -> led[1] never high; led[2] is high 60 of 64 clk, low 4 clk at the end of each period.
REQ-031 Back-pressure: two back-to-back writes (ch0=3, ch1=5) -> first accepted, duty_ready=0 until wrap, second accepted in the clk after the wrap, then committed one period later.
REQ-032 Write on wrap cycle: write ch3=4 accepted exactly in the wrap clk -> led[3] stays 0 for that period and toggles (16 high / 48 low) from the following period.
REQ-033 PRESCALE=1 build: period_start every 16 clk; ch0=1 gives led[0] high 1 clk per period.
